// File: rtl/sys_bus_pkg.sv
// Shared definitions for the processor-to-device bridge: FSM encoding,
// bridge-local register offsets and error status bit positions.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } bridge_state_e;

  localparam logic [1:0] REG_IRQ_MASK = 2'd0;
  localparam logic [1:0] REG_IRQ_PEND = 2'd1;
  localparam logic [1:0] REG_ERR_STAT = 2'd2;
  localparam logic [1:0] REG_ERR_ADDR = 2'd3;

  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_UNMAPPED = 1;

  localparam int HWINT_W = 6;

endpackage

// File: rtl/sys_bridge_irq.sv
// Interrupt mask register, raw pending view and the registered, masked
// interrupt vector presented to the CPU.
module sys_bridge_irq
  import sys_bus_pkg::*;
#(
  parameter int NDEV = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NDEV-1:0]    dev_irq,
  input  logic               mask_we,
  input  logic [NDEV-1:0]    mask_wdata,
  output logic [NDEV-1:0]    irq_mask,
  output logic [NDEV-1:0]    irq_pend,
  output logic [HWINT_W-1:0] hw_int
);

  logic [HWINT_W-1:0] hw_int_nxt;

  always_comb begin
    hw_int_nxt = '0;
    hw_int_nxt[NDEV-1:0] = dev_irq & irq_mask;
  end

  assign irq_pend = dev_irq;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      irq_mask <= '0;
      hw_int   <= '0;
    end else begin
      if (mask_we) irq_mask <= mask_wdata;
      hw_int <= hw_int_nxt;
    end
  end

endmodule

// File: rtl/sys_bridge_n.sv
// Processor bus to NDEV generic slave slots: address decode, access FSM with
// per-slave wait states, timeout watchdog, unmapped detection and local registers.
module sys_bridge_n
  import sys_bus_pkg::*;
#(
  parameter int NDEV     = 4,
  parameter int SEL_LSB  = 8,
  parameter int SEL_BITS = 3,
  parameter int DEV_AW   = 6,
  parameter int TIMEOUT  = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [29:0]          PrA,
  input  logic [3:0]           PrBE,
  input  logic [31:0]          PrWData,
  input  logic                 PrRW,
  input  logic                 PrReq,
  output logic [31:0]          PrRData,
  output logic                 PrReady,
  output logic [5:0]           HWInt,
  output logic [DEV_AW-1:0]    DevA,
  output logic [31:0]          DevWData,
  output logic [3:0]           DevBE,
  output logic [NDEV-1:0]      DevWe,
  output logic [NDEV-1:0]      DevRe,
  input  logic [32*NDEV-1:0]   DevRData,
  input  logic [NDEV-1:0]      DevReady,
  input  logic [NDEV-1:0]      DevIrq
);

  // Slot field expressed in word-address (PrA) bit positions.
  localparam int SEL_HI     = SEL_LSB + SEL_BITS - 3;
  localparam int SEL_LO     = SEL_LSB - 2;
  localparam int LOCAL_SLOT = (1 << SEL_BITS) - 1;
  localparam int CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [SEL_BITS-1:0] LOCAL_SEL = SEL_BITS'(LOCAL_SLOT);
  // Watchdog counts strobed cycles; ACCESS is the first, so WAIT aborts on
  // the TIMEOUT-th strobed cycle that ends without DevReady.
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TIMEOUT - 2);

  bridge_state_e         state, state_nxt;
  logic [29:0]           req_addr;
  logic                  req_rw;
  logic [SEL_BITS-1:0]   req_slot;
  logic [CNT_W-1:0]      wait_cnt;
  logic [31:0]           rdata_q, rdata_nxt;
  logic [1:0]            err_stat, err_nxt;
  logic [31:0]           err_addr;

  logic [NDEV-1:0]       dev_onehot;
  logic [31:0]           dev_rdata_sel;
  logic                  slot_is_dev, slot_is_local;
  logic                  dev_ready_sel, strobe_on;
  logic                  dev_done, timeout_hit, unmapped_hit, local_acc;
  logic [1:0]            reg_off;
  logic                  mask_we, err_w1c;
  logic [31:0]           local_rdata;
  logic [NDEV-1:0]       irq_mask, irq_pend;

  always_comb begin
    dev_onehot    = '0;
    dev_rdata_sel = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (req_slot == SEL_BITS'(i)) begin
        dev_onehot[i] = 1'b1;
        dev_rdata_sel = DevRData[32*i +: 32];
      end
    end
  end

  assign slot_is_dev   = |dev_onehot;
  assign slot_is_local = (req_slot == LOCAL_SEL);
  assign dev_ready_sel = |(DevReady & dev_onehot);
  assign strobe_on     = (state == ST_ACCESS) || (state == ST_WAIT);
  assign DevWe         = (strobe_on && req_rw)  ? dev_onehot : '0;
  assign DevRe         = (strobe_on && !req_rw) ? dev_onehot : '0;

  // Valid/ready: PrReq is held by the CPU until the single-cycle PrReady pulse;
  // a slot's DevReady is only observed while that slot's strobe is asserted.
  always_comb begin
    state_nxt    = state;
    dev_done     = 1'b0;
    timeout_hit  = 1'b0;
    unmapped_hit = 1'b0;
    local_acc    = 1'b0;
    case (state)
      ST_IDLE: if (PrReq) state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (!slot_is_dev) begin
          state_nxt = ST_DONE;
          if (slot_is_local) local_acc = 1'b1;
          else               unmapped_hit = 1'b1;
        end else if (dev_ready_sel) begin
          dev_done  = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dev_ready_sel) begin
          dev_done  = 1'b1;
          state_nxt = ST_DONE;
        end else if (wait_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign reg_off = DevA[1:0];
  assign mask_we = local_acc && req_rw && DevBE[0] && (reg_off == REG_IRQ_MASK);
  assign err_w1c = local_acc && req_rw && DevBE[0] && (reg_off == REG_ERR_STAT);

  always_comb begin
    local_rdata = '0;
    case (reg_off)
      REG_IRQ_MASK: local_rdata = {{(32-NDEV){1'b0}}, irq_mask};
      REG_IRQ_PEND: local_rdata = {{(32-NDEV){1'b0}}, irq_pend};
      REG_ERR_STAT: local_rdata = {30'd0, err_stat};
      REG_ERR_ADDR: local_rdata = err_addr;
      default:      local_rdata = '0;
    endcase
  end

  // Error capture is applied after the clear so a new error always survives.
  always_comb begin
    err_nxt = err_stat;
    if (err_w1c)      err_nxt = err_stat & ~DevWData[1:0];
    if (timeout_hit)  err_nxt[ERR_TIMEOUT]  = 1'b1;
    if (unmapped_hit) err_nxt[ERR_UNMAPPED] = 1'b1;
  end

  always_comb begin
    rdata_nxt = rdata_q;
    if (dev_done)                         rdata_nxt = req_rw ? 32'd0 : dev_rdata_sel;
    else if (timeout_hit || unmapped_hit) rdata_nxt = 32'd0;
    else if (local_acc)                   rdata_nxt = req_rw ? 32'd0 : local_rdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      req_addr <= '0;
      req_rw   <= 1'b0;
      req_slot <= '0;
      DevA     <= '0;
      DevWData <= '0;
      DevBE    <= '0;
      wait_cnt <= '0;
      rdata_q  <= '0;
      err_stat <= '0;
      err_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && PrReq) begin
        req_addr <= PrA;
        req_rw   <= PrRW;
        req_slot <= PrA[SEL_HI:SEL_LO];
        DevA     <= PrA[DEV_AW-1:0];
        DevWData <= PrWData;
        DevBE    <= PrBE;
      end
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + CNT_W'(1) : '0;
      rdata_q  <= rdata_nxt;
      err_stat <= err_nxt;
      if (timeout_hit || unmapped_hit) err_addr <= {req_addr, 2'b00};
    end
  end

  assign PrReady = (state == ST_DONE);
  assign PrRData = rdata_q;

  sys_bridge_irq #(.NDEV(NDEV)) u_irq (
    .Clk        (Clk),
    .Reset      (Reset),
    .dev_irq    (DevIrq),
    .mask_we    (mask_we),
    .mask_wdata (DevWData[NDEV-1:0]),
    .irq_mask   (irq_mask),
    .irq_pend   (irq_pend),
    .hw_int     (HWInt)
  );

endmodule

// File: tb/tb_sys_bridge_n.sv
// Bench for sys_bridge_n: directed vector table, reset/interrupt sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_sys_bridge_n;

  localparam int NDEV    = 4;
  localparam int DEV_AW  = 6;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic              Clk, Reset;
  logic [29:0]       PrA;
  logic [3:0]        PrBE;
  logic [31:0]       PrWData;
  logic              PrRW, PrReq;
  logic [31:0]       PrRData;
  logic              PrReady;
  logic [5:0]        HWInt;
  logic [DEV_AW-1:0] DevA;
  logic [31:0]       DevWData;
  logic [3:0]        DevBE;
  logic [NDEV-1:0]   DevWe, DevRe;
  logic [32*NDEV-1:0] DevRData;
  logic [NDEV-1:0]   DevReady, DevIrq;

  sys_bridge_n #(.NDEV(NDEV), .SEL_LSB(8), .SEL_BITS(3), .DEV_AW(DEV_AW), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .PrA(PrA), .PrBE(PrBE), .PrWData(PrWData), .PrRW(PrRW),
    .PrReq(PrReq), .PrRData(PrRData), .PrReady(PrReady), .HWInt(HWInt), .DevA(DevA),
    .DevWData(DevWData), .DevBE(DevBE), .DevWe(DevWe), .DevRe(DevRe), .DevRData(DevRData),
    .DevReady(DevReady), .DevIrq(DevIrq)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // device slot models: fixed read data, ready after dlat prior strobed cycles
  logic [31:0] dev_data [NDEV];
  int          dlat [NDEV];
  int          scnt [NDEV];

  initial begin
    dev_data[0] = 32'hD000_0000;
    dev_data[1] = 32'h1234_5678;
    dev_data[2] = 32'hDEAD_BEEF;
    dev_data[3] = 32'h3333_3333;
    for (int i = 0; i < NDEV; i++) begin
      dlat[i] = 0;
      scnt[i] = 0;
    end
  end

  always_comb begin
    DevRData = '0;
    DevReady = '0;
    for (int i = 0; i < NDEV; i++) begin
      DevRData[32*i +: 32] = dev_data[i];
      DevReady[i] = (DevWe[i] || DevRe[i]) && (dlat[i] < NEVER) && (scnt[i] >= dlat[i]);
    end
  end

  always @(posedge Clk) begin
    for (int i = 0; i < NDEV; i++)
      scnt[i] <= (DevWe[i] || DevRe[i]) ? scnt[i] + 1 : 0;
  end

  // write monitor: records every completed device write
  int          wr_seen = 0;
  logic [44:0] wr_last = '0;
  always @(posedge Clk) begin
    for (int i = 0; i < NDEV; i++) begin
      if (DevWe[i] && DevReady[i]) begin
        wr_seen <= wr_seen + 1;
        wr_last <= {3'(i), DevA, DevBE, DevWData};
      end
    end
  end

  // scoreboard
  logic [44:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // reference model: bridge-visible state and per-transaction outcome
  logic [NDEV-1:0] m_mask;
  logic [1:0]      m_err;
  logic [31:0]     m_erraddr;

  task automatic model_reset();
    m_mask = '0; m_err = '0; m_erraddr = '0;
  endtask

  task automatic model_txn(input logic [31:0] baddr, input logic rw, input logic [31:0] wdata,
                           input logic [3:0] be, input int dl,
                           output logic [31:0] rd, output int lat, output int str);
    int slot = int'(baddr[10:8]);
    int off  = int'(baddr[3:2]);
    rd = 32'd0; lat = 2; str = 0;
    if (slot < NDEV) begin
      if (dl <= TIMEOUT - 1) begin
        lat = dl + 2; str = dl + 1;
        if (!rw) rd = dev_data[slot];
      end else begin
        lat = TIMEOUT + 1; str = TIMEOUT;
        m_err[0] = 1'b1; m_erraddr = {baddr[31:2], 2'b00};
      end
    end else if (slot == 7) begin
      if (!rw) begin
        case (off)
          0: rd = 32'(m_mask);
          1: rd = 32'(DevIrq);
          2: rd = 32'(m_err);
          default: rd = m_erraddr;
        endcase
      end else if (be[0]) begin
        if (off == 0) m_mask = wdata[NDEV-1:0];
        if (off == 2) m_err  = m_err & ~wdata[1:0];
      end
    end else begin
      m_err[1] = 1'b1; m_erraddr = {baddr[31:2], 2'b00};
    end
  endtask

  // driver: one full CPU transaction with protocol and result checks
  task automatic run_txn(input string name, input logic [31:0] baddr, input logic rw,
                         input logic [31:0] wdata, input logic [3:0] be, input int dl,
                         input logic [31:0] exp_rd, input int exp_lat, input int exp_str);
    logic [2:0]      slot = baddr[10:8];
    logic [NDEV-1:0] pat = '0;
    logic [31:0]     rd = '0;
    logic [44:0]     e;
    int n = 0, nstr = 0, nbad = 0, seen0, exp_wr = 0;
    bit got = 0;
    if (int'(slot) < NDEV) begin
      dlat[slot] = dl;
      pat[slot] = 1'b1;
      if (rw && dl <= TIMEOUT - 1) begin
        exp_q.push_back({slot, baddr[7:2], be, wdata});
        exp_wr = 1;
      end
    end
    seen0 = wr_seen;
    PrA = baddr[31:2]; PrRW = rw; PrWData = wdata; PrBE = be; PrReq = 1'b1;
    while (n < 200) begin
      @(posedge Clk); #1;
      n++;
      if ((DevWe | DevRe) != '0) begin
        nstr++;
        if (rw ? (DevWe != pat || DevRe != '0) : (DevRe != pat || DevWe != '0)) nbad++;
      end
      if (PrReady) begin
        got = 1; rd = PrRData;
        break;
      end
    end
    PrReq = 1'b0;
    check32({name, " ready_seen"}, 32'(got), 32'd1);
    check32({name, " latency"}, 32'(n), 32'(exp_lat));
    check32({name, " strobe_cycles"}, 32'(nstr), 32'(exp_str));
    check32({name, " strobe_pattern_bad"}, 32'(nbad), 32'd0);
    if (!rw) check32({name, " rdata"}, rd, exp_rd);
    check32({name, " dev_writes"}, 32'(wr_seen - seen0), 32'(exp_wr));
    if (exp_wr == 1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (wr_last !== e) begin
        errors++;
        $display("FAIL %s dev_write_word: got 0x%012h expected 0x%012h", name, wr_last, e);
      end
    end
    @(posedge Clk); #1;
    check32({name, " ready_pulse_end"}, 32'(PrReady), 32'd0);
    check32({name, " hwint"}, 32'(HWInt), 32'({2'b00, DevIrq & m_mask}));
  endtask

  typedef struct {
    string       name;
    logic [31:0] baddr;
    logic        rw;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          dl;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_str;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic [31:0] a, input logic rw, input logic [31:0] wd,
                     input logic [3:0] be, input int dl, input logic [31:0] er, input int el,
                     input int es);
    vec_t v;
    v.name = nm; v.baddr = a; v.rw = rw; v.wdata = wd; v.be = be; v.dl = dl;
    v.exp_rd = er; v.exp_lat = el; v.exp_str = es;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] mrd, baddr, wd;
    logic        rw;
    logic [3:0]  be;
    int          mlat, mstr, dl, r, slot;
    bit          spurious;

    Reset = 1'b1; PrA = '0; PrBE = '0; PrWData = '0; PrRW = 1'b0; PrReq = 1'b0;
    DevIrq = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check32("rst PrReady", 32'(PrReady), 32'd0);
    check32("rst PrRData", PrRData, 32'd0);
    check32("rst DevWe_DevRe", 32'({DevWe, DevRe}), 32'd0);
    check32("rst DevA", 32'(DevA), 32'd0);
    check32("rst DevWData", DevWData, 32'd0);
    check32("rst DevBE", 32'(DevBE), 32'd0);
    check32("rst HWInt", 32'(HWInt), 32'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // directed vectors
    add("zero_wait_rd",   32'h0000_0110, 0, 32'h0,         4'h0, 0,     32'h1234_5678, 2,  1);
    add("wait_wr",        32'h0000_0004, 1, 32'hA5A5_0F0F, 4'hF, 5,     32'h0,         7,  6);
    add("timeout_rd",     32'hF000_0208, 0, 32'h0,         4'h0, NEVER, 32'h0,         17, 16);
    add("err_stat_to",    32'h0000_0708, 0, 32'h0,         4'h0, 0,     32'h1,         2,  0);
    add("err_addr_to",    32'h0000_070C, 0, 32'h0,         4'h0, 0,     32'hF000_0208, 2,  0);
    add("err_w1c",        32'h0000_0708, 1, 32'h1,         4'h1, 0,     32'h0,         2,  0);
    add("err_clr",        32'h0000_0708, 0, 32'h0,         4'h0, 0,     32'h0,         2,  0);
    add("unmapped_rd",    32'h0000_0500, 0, 32'h0,         4'h0, 0,     32'h0,         2,  0);
    add("err_stat_um",    32'h0000_0708, 0, 32'h0,         4'h0, 0,     32'h2,         2,  0);
    add("err_addr_um",    32'h0000_070C, 0, 32'h0,         4'h0, 0,     32'h0000_0500, 2,  0);
    add("unmapped_wr",    32'h0000_0614, 1, 32'hFFFF_FFFF, 4'hF, 0,     32'h0,         2,  0);
    add("err_addr_um2",   32'h0000_070C, 0, 32'h0,         4'h0, 0,     32'h0000_0614, 2,  0);
    add("mask_wr",        32'h0000_0700, 1, 32'h5,         4'h1, 0,     32'h0,         2,  0);
    add("mask_rd",        32'h0000_0700, 0, 32'h0,         4'h0, 0,     32'h5,         2,  0);
    add("mask_wr_nobe0",  32'h0000_0700, 1, 32'hF,         4'hE, 0,     32'h0,         2,  0);
    add("mask_rd2",       32'h0000_0700, 0, 32'h0,         4'h0, 0,     32'h5,         2,  0);
    add("pend_rd",        32'h0000_0704, 0, 32'h0,         4'h0, 0,     32'hA,         2,  0);
    add("err_w1c_all",    32'h0000_0708, 1, 32'h3,         4'h1, 0,     32'h0,         2,  0);
    add("err_clr2",       32'h0000_0708, 0, 32'h0,         4'h0, 0,     32'h0,         2,  0);
    add("slot3_rd_w2",    32'h0000_0300, 0, 32'h0,         4'h0, 2,     32'h3333_3333, 4,  3);
    add("last_cycle_rdy", 32'h0000_0100, 0, 32'h0,         4'h0, 15,    32'h1234_5678, 17, 16);
    add("one_late_to",    32'h0000_0208, 0, 32'h0,         4'h0, 16,    32'h0,         17, 16);
    add("err_stat_to2",   32'h0000_0708, 0, 32'h0,         4'h0, 0,     32'h1,         2,  0);

    DevIrq = 4'b1010;
    for (int k = 0; k < tbl.size(); k++) begin
      model_txn(tbl[k].baddr, tbl[k].rw, tbl[k].wdata, tbl[k].be, tbl[k].dl, mrd, mlat, mstr);
      run_txn(tbl[k].name, tbl[k].baddr, tbl[k].rw, tbl[k].wdata, tbl[k].be, tbl[k].dl,
              tbl[k].exp_rd, tbl[k].exp_lat, tbl[k].exp_str);
    end

    // interrupt masking: mask is 0101 here
    check32("irq idle hwint", 32'(HWInt), 32'd0);
    DevIrq = 4'b1111;
    @(posedge Clk); #1;
    check32("irq masked hwint", 32'(HWInt), 32'b000101);
    model_txn(32'h700, 1, 32'h0, 4'h1, 0, mrd, mlat, mstr);
    run_txn("mask_zero", 32'h700, 1, 32'h0, 4'h1, 0, mrd, mlat, mstr);

    // reset in the middle of a WAIT
    model_txn(32'h700, 1, 32'h3, 4'h1, 0, mrd, mlat, mstr);
    run_txn("mask_three", 32'h700, 1, 32'h3, 4'h1, 0, mrd, mlat, mstr);
    dlat[3] = NEVER;
    PrA = 30'h0000_00C0; PrRW = 1'b0; PrBE = 4'h0; PrReq = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    check32("rstwait DevRe active", 32'(DevRe), 32'b1000);
    Reset = 1'b1; PrReq = 1'b0;
    @(posedge Clk); #1;
    check32("rstwait PrReady", 32'(PrReady), 32'd0);
    check32("rstwait strobes", 32'({DevWe, DevRe}), 32'd0);
    check32("rstwait PrRData", PrRData, 32'd0);
    check32("rstwait HWInt", 32'(HWInt), 32'd0);
    Reset = 1'b0;
    model_reset();
    spurious = 0;
    repeat (3) begin
      @(posedge Clk); #1;
      if (PrReady) spurious = 1;
    end
    check32("rstwait no_ready", 32'(spurious), 32'd0);
    model_txn(32'h700, 0, 32'h0, 4'h0, 0, mrd, mlat, mstr);
    run_txn("post_rst_mask", 32'h700, 0, 32'h0, 4'h0, 0, 32'h0, 2, 0);
    model_txn(32'h300, 0, 32'h0, 4'h0, 1, mrd, mlat, mstr);
    run_txn("post_rst_rd", 32'h300, 0, 32'h0, 4'h0, 1, 32'h3333_3333, 3, 2);

    // randomized traffic against the reference model
    for (int k = 0; k < 60; k++) begin
      slot  = $urandom_range(0, 7);
      baddr = ($urandom() & 32'hFFFF_F8FC) | (32'(slot) << 8);
      rw    = 1'($urandom_range(0, 1));
      wd    = $urandom();
      be    = 4'($urandom_range(0, 15));
      r     = $urandom_range(0, 9);
      dl    = (r < 7) ? (r % 4) : (r == 7) ? TIMEOUT - 1 : (r == 8) ? TIMEOUT : NEVER;
      DevIrq = 4'($urandom_range(0, 15));
      model_txn(baddr, rw, wd, be, dl, mrd, mlat, mstr);
      run_txn($sformatf("rand%0d", k), baddr, rw, wd, be, dl, mrd, mlat, mstr);
    end

    check32("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
